// File: rtl/tank_spawn_sched_if.sv
// ----------------------------------------------------------------------------
// tank_spawn_sched_if
// Groups the game-side signals of the enemy tank spawn scheduler.
//
// Signals:
//   tick        game -> sched  one-cycle slow game tick strobe
//   game_en     game -> sched  level, 1 = spawning allowed
//   tank_state  game -> sched  per-slot alive flags (bit i = enemy slot i)
//   tank_en     sched -> game  one-hot, one-cycle spawn grant
//   spawn_idx   sched -> game  index of the most recently granted slot
//   busy        sched -> game  scheduler FSM is not idle
//   spawn_count sched -> game  total grants issued, saturating at 255
//
// Modports:
//   master  the game logic (drives tick/game_en/tank_state)
//   slave   the scheduler
// ----------------------------------------------------------------------------
interface tank_spawn_sched_if;
    logic       tick;
    logic       game_en;
    logic [3:0] tank_state;
    logic [3:0] tank_en;
    logic [1:0] spawn_idx;
    logic       busy;
    logic [7:0] spawn_count;

    modport master (
        output tick, game_en, tank_state,
        input  tank_en, spawn_idx, busy, spawn_count
    );

    modport slave (
        input  tick, game_en, tank_state,
        output tank_en, spawn_idx, busy, spawn_count
    );
endinterface

// File: rtl/tank_spawn_sched.sv
// ----------------------------------------------------------------------------
// tank_spawn_sched
// Enemy tank spawn scheduler. After a cooldown of COOLDOWN_TICKS game ticks
// it grants a spawn to the next dead enemy slot in round-robin order,
// provided fewer than MAX_ALIVE tanks are alive. Each grant is a one-cycle
// one-hot pulse on tank_en.
//
// Optional feature (macro SPAWN_ACK_EN): after a grant the FSM waits in ACK
// until the granted slot reports alive or ACK_TIMEOUT clk cycles elapse.
// With the macro undefined no ACK state or timer exists.
//
// Parameters:
//   COOLDOWN_TICKS  0..15   ticks between successive grants
//   MAX_ALIVE       1..4    cap on simultaneously alive tanks
//   ACK_TIMEOUT     1..255  ack wait in clk cycles (SPAWN_ACK_EN only)
//
// Ports:
//   clk   system clock
//   rst   asynchronous active-high reset
//   bus   tank_spawn_sched_if.slave (tick, game_en, tank_state in;
//         tank_en, spawn_idx, busy, spawn_count out)
// ----------------------------------------------------------------------------
module tank_spawn_sched #(
    parameter int COOLDOWN_TICKS = 4,
    parameter int MAX_ALIVE      = 4,
    parameter int ACK_TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    tank_spawn_sched_if.slave     bus
);

    // Elaboration-time parameter range checks.
    if (COOLDOWN_TICKS < 0 || COOLDOWN_TICKS > 15) begin : g_bad_cooldown
        $error("COOLDOWN_TICKS out of range 0..15");
    end
    if (MAX_ALIVE < 1 || MAX_ALIVE > 4) begin : g_bad_max_alive
        $error("MAX_ALIVE out of range 1..4");
    end
    if (ACK_TIMEOUT < 1 || ACK_TIMEOUT > 255) begin : g_bad_ack_timeout
        $error("ACK_TIMEOUT out of range 1..255");
    end

    localparam logic [3:0] CNT_LOAD   = 4'(COOLDOWN_TICKS);
    localparam logic [2:0] ALIVE_CAP  = 3'(MAX_ALIVE);

`ifdef SPAWN_ACK_EN
    localparam logic [7:0] ACK_LOAD   = 8'(ACK_TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_COOLDOWN = 2'd1,
        ST_GRANT    = 2'd2,
        ST_ACK      = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_COOLDOWN = 2'd1,
        ST_GRANT    = 2'd2
    } state_t;
`endif

    state_t     r_state;
    logic [3:0] r_cnt;
    logic [1:0] r_rr_ptr;
    logic [3:0] r_tank_en;
    logic [1:0] r_spawn_idx;
    logic [7:0] r_spawn_count;
`ifdef SPAWN_ACK_EN
    logic [7:0] r_ack_tmr;
`endif

    logic [2:0] w_alive;
    logic       w_sel_found;
    logic [1:0] w_sel_idx;
    logic [1:0] w_probe;
    logic       w_grant_ok;

    // Number of currently alive enemy tanks.
    assign w_alive = {2'b00, bus.tank_state[0]} + {2'b00, bus.tank_state[1]}
                   + {2'b00, bus.tank_state[2]} + {2'b00, bus.tank_state[3]};

    // Round-robin search for the first dead slot, starting just after the
    // last granted slot. The 2-bit probe wraps naturally, so k=4 revisits
    // rr_ptr itself as the last candidate.
    // NOTE: every signal written here gets a default before the loop, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_sel_found = 1'b0;
        w_sel_idx   = 2'd0;
        w_probe     = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            w_probe = r_rr_ptr + 2'(k);
            if (!w_sel_found && !bus.tank_state[w_probe]) begin
                w_sel_found = 1'b1;
                w_sel_idx   = w_probe;
            end
        end
    end

    assign w_grant_ok = w_sel_found && (w_alive < ALIVE_CAP);

    // Single FSM block; every output is a register updated here.
    // NOTE: sequential state uses non-blocking assignments so all registers
    // sample pre-edge values, regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_cnt         <= 4'd0;
            r_rr_ptr      <= 2'd3;
            r_tank_en     <= 4'b0000;
            r_spawn_idx   <= 2'd0;
            r_spawn_count <= 8'd0;
`ifdef SPAWN_ACK_EN
            r_ack_tmr     <= 8'd0;
`endif
        end else begin
            // Grant pulse lasts exactly one cycle: cleared unless re-armed.
            r_tank_en <= 4'b0000;

            if (!bus.game_en) begin
                // Abort from any state; grant history is kept.
                r_state <= ST_IDLE;
                r_cnt   <= 4'd0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        // A tick on this edge is ignored: cnt is freshly loaded.
                        r_state <= ST_COOLDOWN;
                        r_cnt   <= CNT_LOAD;
                    end

                    ST_COOLDOWN: begin
                        if (r_cnt == 4'd0) begin
                            if (w_grant_ok) begin
                                // Slot choice is latched here; later
                                // tank_state changes cannot alter it.
                                r_state     <= ST_GRANT;
                                r_tank_en   <= 4'b0001 << w_sel_idx;
                                r_rr_ptr    <= w_sel_idx;
                                r_spawn_idx <= w_sel_idx;
                                if (r_spawn_count != 8'hFF) begin
                                    r_spawn_count <= r_spawn_count + 8'd1;
                                end
                            end
                        end else if (bus.tick) begin
                            r_cnt <= r_cnt - 4'd1;
                        end
                    end

                    ST_GRANT: begin
`ifdef SPAWN_ACK_EN
                        r_state   <= ST_ACK;
                        r_ack_tmr <= ACK_LOAD;
`else
                        r_state <= ST_COOLDOWN;
                        r_cnt   <= CNT_LOAD;
`endif
                    end

`ifdef SPAWN_ACK_EN
                    ST_ACK: begin
                        // Leave on acknowledge, or on the edge where the
                        // timer would reach zero.
                        if (bus.tank_state[r_spawn_idx] || r_ack_tmr <= 8'd1) begin
                            r_state   <= ST_COOLDOWN;
                            r_cnt     <= CNT_LOAD;
                            r_ack_tmr <= 8'd0;
                        end else begin
                            r_ack_tmr <= r_ack_tmr - 8'd1;
                        end
                    end
`endif

                    default: begin
                        r_state <= ST_IDLE;
                        r_cnt   <= 4'd0;
                    end
                endcase
            end
        end
    end

    assign bus.tank_en     = r_tank_en;
    assign bus.spawn_idx   = r_spawn_idx;
    assign bus.spawn_count = r_spawn_count;
    assign bus.busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_tank_spawn_sched.sv
// ----------------------------------------------------------------------------
// tb_tank_spawn_sched
// Directed bench for tank_spawn_sched in the default build. Instance A uses
// the default parameters; instance B uses MAX_ALIVE=2, COOLDOWN_TICKS=0.
// ----------------------------------------------------------------------------
module tb_tank_spawn_sched;

    logic clk;
    logic rst;

    int checks;
    int failures;
    int exp_cnt_a;

    tank_spawn_sched_if bus_a ();
    tank_spawn_sched_if bus_b ();

    tank_spawn_sched u_dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    tank_spawn_sched #(
        .COOLDOWN_TICKS (0),
        .MAX_ALIVE      (2),
        .ACK_TIMEOUT    (16)
    ) u_dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks_a(input int n);
        repeat (n) begin
            bus_a.tick = 1'b1;
            step();
        end
        bus_a.tick = 1'b0;
    endtask

    // One full cooldown + grant on instance A, starting in COOLDOWN with a
    // freshly loaded counter of 4.
    task automatic grant_a(input string tag, input logic [3:0] exp_en, input logic [1:0] exp_idx);
        ticks_a(4);
        check({tag, "_pre"}, {4'h0, bus_a.tank_en}, 8'h00);
        step();
        if (exp_cnt_a != 255) exp_cnt_a++;
        check({tag, "_en"},  {4'h0, bus_a.tank_en}, {4'h0, exp_en});
        check({tag, "_idx"}, {6'h0, bus_a.spawn_idx}, {6'h0, exp_idx});
        check({tag, "_cnt"}, bus_a.spawn_count, 8'(exp_cnt_a));
        step();
        check({tag, "_post"}, {4'h0, bus_a.tank_en}, 8'h00);
    endtask

    initial begin
        logic [3:0] seen;
        checks    = 0;
        failures  = 0;
        exp_cnt_a = 0;

        rst              = 1'b1;
        bus_a.tick       = 1'b0;
        bus_a.game_en    = 1'b0;
        bus_a.tank_state = 4'b0000;
        bus_b.tick       = 1'b0;
        bus_b.game_en    = 1'b0;
        bus_b.tank_state = 4'b0000;

        // Reset values, before any clock edge.
        #3;
        check("rst_en",    {4'h0, bus_a.tank_en}, 8'h00);
        check("rst_idx",   {6'h0, bus_a.spawn_idx}, 8'h00);
        check("rst_busy",  {7'h0, bus_a.busy}, 8'h00);
        check("rst_cnt",   bus_a.spawn_count, 8'h00);
        check("rst_b_busy", {7'h0, bus_b.busy}, 8'h00);

        // game_en high during reset must not start the FSM.
        bus_a.game_en = 1'b1;
        step();
        step();
        check("rst_hold_busy", {7'h0, bus_a.busy}, 8'h00);
        rst = 1'b0;

        // Entry into COOLDOWN with a coincident tick: cnt must stay at 4.
        bus_a.tick = 1'b1;
        step();
        bus_a.tick = 1'b0;
        check("entry_busy", {7'h0, bus_a.busy}, 8'h01);
        check("entry_en",   {4'h0, bus_a.tank_en}, 8'h00);

        // Round robin with all slots dead.
        grant_a("rr0", 4'b0001, 2'd0);
        grant_a("rr1", 4'b0010, 2'd1);
        grant_a("rr2", 4'b0100, 2'd2);
        grant_a("rr3", 4'b1000, 2'd3);
        grant_a("rr4", 4'b0001, 2'd0);
        grant_a("rr5", 4'b0010, 2'd1);
        grant_a("rr6", 4'b0100, 2'd2);
        grant_a("rr7", 4'b1000, 2'd3);

        // rr_ptr=3, slots 0 and 2 alive: skip to 1, then 3.
        bus_a.tank_state = 4'b0101;
        grant_a("skip0", 4'b0010, 2'd1);
        grant_a("skip1", 4'b1000, 2'd3);

        // Abort on the would-be grant edge.
        ticks_a(4);
        bus_a.game_en = 1'b0;
        step();
        check("abort_en",   {4'h0, bus_a.tank_en}, 8'h00);
        check("abort_busy", {7'h0, bus_a.busy}, 8'h00);
        check("abort_cnt",  bus_a.spawn_count, 8'd10);
        check("abort_idx",  {6'h0, bus_a.spawn_idx}, 8'd3);
        bus_a.game_en = 1'b1;
        step();
        check("resume_busy", {7'h0, bus_a.busy}, 8'h01);
        grant_a("resume", 4'b0010, 2'd1);

        // Saturation: 244 more grants bring the count to 255.
        bus_a.tank_state = 4'b0000;
        repeat (244) begin
            ticks_a(4);
            step();
            step();
        end
        exp_cnt_a = 255;
        check("sat_cnt", bus_a.spawn_count, 8'd255);
        // Last of 11+244 grants went to (1+244) mod 4 = 1, so next is slot 2.
        grant_a("sat", 4'b0100, 2'd2);

        // Reset in the middle of a GRANT cycle.
        ticks_a(4);
        step();
        check("pre_rst_en", {4'h0, bus_a.tank_en}, 8'h08);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_en",   {4'h0, bus_a.tank_en}, 8'h00);
        check("midrst_cnt",  bus_a.spawn_count, 8'h00);
        check("midrst_busy", {7'h0, bus_a.busy}, 8'h00);
        check("midrst_idx",  {6'h0, bus_a.spawn_idx}, 8'h00);
        step();
        rst = 1'b0;
        exp_cnt_a = 0;

        // First grant after reset starts from slot 0; slot 0 alive -> slot 1.
        bus_a.tank_state = 4'b0001;
        step();
        grant_a("post_rst", 4'b0010, 2'd1);
        bus_a.game_en = 1'b0;

        // Instance B: cap of 2 alive, zero cooldown.
        bus_b.tank_state = 4'b0011;
        bus_b.game_en    = 1'b1;
        step();
        check("cap_busy", {7'h0, bus_b.busy}, 8'h01);
        seen = 4'b0000;
        repeat (20) begin
            bus_b.tick = 1'b1;
            step();
            seen = seen | bus_b.tank_en;
        end
        bus_b.tick = 1'b0;
        check("cap_hold", {4'h0, seen}, 8'h00);
        bus_b.tank_state = 4'b0010;
        step();
        check("cap_rel_en",  {4'h0, bus_b.tank_en}, 8'h01);
        check("cap_rel_idx", {6'h0, bus_b.spawn_idx}, 8'h00);
        check("cap_rel_cnt", bus_b.spawn_count, 8'd1);
        bus_b.tank_state = 4'b0000;
        step();
        check("cd0_gap_en", {4'h0, bus_b.tank_en}, 8'h00);
        step();
        check("cd0_en",  {4'h0, bus_b.tank_en}, 8'h02);
        check("cd0_cnt", bus_b.spawn_count, 8'd2);
        step();
        check("cd0_post_en", {4'h0, bus_b.tank_en}, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
